input_conditioner: RTL

Multi-channel input conditioning block for asynchronous external signals such as comparator outputs, buttons and board strobes. Each channel passes through a parametrised-depth flip-flop synchroniser, then a per-channel debounce filter, then a rise/fall edge detector. Downstream ADC control logic consumes either the raw synchronised level or the debounced level with single-cycle edge pulses. It replaces ad-hoc fixed two-stage synchronisers wherever filtering or edge events are needed.

---
 rtl/cond_pkg.sv | 13 +
 rtl/cond_channel.sv | 76 +++++++
 rtl/input_conditioner.sv | 43 ++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared constants and helpers for the input conditioning blocks.
package cond_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    // Debounce counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cond_channel.sv
// One conditioned input bit: flip-flop synchroniser, debounce counter and
// registered rise/fall pulses on the debounced level.
module cond_channel
    import cond_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT            = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              stable_reg;
    logic              stable_next;
    logic              rise_reg;
    logic              fall_reg;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= {STAGES{INIT}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

    // Any cycle where the synchronised level agrees with the accepted one
    // throws away the partial count.
    always_comb begin
        accept      = 1'b0;
        count_next  = count_reg;
        stable_next = stable_reg;
        if (sync_out == stable_reg) begin
            count_next = '0;
        end else if (count_reg == CNT_LAST) begin
            accept      = 1'b1;
            stable_next = sync_out;
            count_next  = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            stable_reg <= INIT;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            count_reg  <= count_next;
            stable_reg <= stable_next;
            rise_reg   <= accept & sync_out;
            fall_reg   <= accept & ~sync_out;
        end
    end

    assign stable_out = stable_reg;
    assign rise_pulse = rise_reg;
    assign fall_pulse = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchronise + debounce + edge-detect front end for
// asynchronous board inputs; every channel is independent.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int                  CHANNELS        = 1,
    parameter int                  STAGES          = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] INIT            = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] stable_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $fatal(1, "input_conditioner: STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $fatal(1, "input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        cond_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT            (INIT[gi])
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .async_in   (async_in[gi]),
            .sync_out   (sync_out[gi]),
            .stable_out (stable_out[gi]),
            .rise_pulse (rise_pulse[gi]),
            .fall_pulse (fall_pulse[gi])
        );
    end

endmodule
